// File: rtl/xperm_pkg.sv
// xperm_pkg: shared encodings and derived constants for the Zbkx crossbar-permutation unit.
package xperm_pkg;
    localparam logic XPERM_OP_8 = 1'b0;
    localparam logic XPERM_OP_4 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } xperm_state_e;

    function automatic int xperm_chunks(input int xlen, input int bytes_per_cycle);
        return (xlen / 8) / bytes_per_cycle;
    endfunction
endpackage

// File: rtl/xperm_byte_lane.sv
// xperm_byte_lane: one result byte, either a byte lookup or two nibble lookups,
// with the full index compared against the element count.
module xperm_byte_lane
    import xperm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            op,
    input  logic [XLEN-1:0] lut,
    input  logic [7:0]      idx,
    output logic [7:0]      res
);
    localparam int NB  = XLEN / 8;
    localparam int NN  = XLEN / 4;
    localparam int BIW = $clog2(NB);
    localparam int NIW = $clog2(NN);

    logic [NB-1:0][7:0] lut_b;
    logic [NN-1:0][3:0] lut_n;
    logic [7:0]         byte_res;
    logic [3:0]         nib_lo, nib_hi;

    assign lut_b = lut;
    assign lut_n = lut;

    assign byte_res = idx < 8'(NB) ? lut_b[idx[BIW-1:0]] : 8'h00;
    assign nib_lo   = {1'b0, idx[3:0]} < 5'(NN) ? lut_n[idx[NIW-1:0]] : 4'h0;
    assign nib_hi   = {1'b0, idx[7:4]} < 5'(NN) ? lut_n[idx[4+NIW-1:4]] : 4'h0;
    assign res      = op == XPERM_OP_4 ? {nib_hi, nib_lo} : byte_res;
endmodule

// File: rtl/xperm_iter_fu.sv
// xperm_iter_fu: multi-cycle xperm8/xperm4 unit producing BYTES_PER_CYCLE result bytes
// per BUSY cycle, with valid/ready request and response handshakes.
module xperm_iter_fu
    import xperm_pkg::*;
#(
    parameter int XLEN            = 64,
    parameter int BYTES_PER_CYCLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rd
);
    localparam int CHUNKS = xperm_chunks(XLEN, BYTES_PER_CYCLE);
    localparam int CW     = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
    localparam int LW     = BYTES_PER_CYCLE * 8;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    xperm_state_e              state, state_n;
    logic [CW-1:0]             cnt;
    logic                      op_q;
    logic [XLEN-1:0]           rs1_q, rs2_q;
    logic [CHUNKS-1:0][LW-1:0] rs1_c, rd_q;
    logic [LW-1:0]             idx_chunk, res_chunk;

    assign rs1_c     = rs1_q;
    assign idx_chunk = rs1_c[cnt];
    assign out_rd    = rd_q;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_lane
        xperm_byte_lane #(.XLEN(XLEN)) u_lane (
            .op  (op_q),
            .lut (rs2_q),
            .idx (idx_chunk[i*8 +: 8]),
            .res (res_chunk[i*8 +: 8])
        );
    end

    always_comb begin
        state_n = state;
        if (flush)
            state_n = IDLE;
        else if (state == IDLE && in_valid)
            state_n = BUSY;
        else if (state == BUSY && cnt == LAST)
            state_n = DONE;
        else if (state == DONE && out_ready)
            state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= XPERM_OP_8;
            rs1_q <= '0;
            rs2_q <= '0;
            rd_q  <= '0;
        end else begin
            state <= state_n;
            if (flush) begin
                cnt <= '0;
            end else if (state == IDLE && in_valid) begin
                cnt   <= '0;
                op_q  <= in_op;
                rs1_q <= in_rs1;
                rs2_q <= in_rs2;
            end else if (state == BUSY) begin
                rd_q[cnt] <= res_chunk;
                if (cnt != LAST)
                    cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_xperm_iter_fu.sv
// tb_xperm_iter_fu: randomized and directed checks of both configurations against
// an element-level permutation model.
module tb_xperm_iter_fu;
    localparam int CHUNKS64 = (64 / 8) / 2;
    localparam int CHUNKS32 = (32 / 8) / 4;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic        in_valid = 1'b0, in_op = 1'b0, out_ready = 1'b1;
    logic [63:0] in_rs1 = '0, in_rs2 = '0;
    logic        in_ready, out_valid;
    logic [63:0] out_rd;
    logic        in_valid_32 = 1'b0, in_op_32 = 1'b0, out_ready_32 = 1'b1;
    logic [31:0] in_rs1_32 = '0, in_rs2_32 = '0;
    logic        in_ready_32, out_valid_32;
    logic [31:0] out_rd_32;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    xperm_iter_fu #(.XLEN(64), .BYTES_PER_CYCLE(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd)
    );

    xperm_iter_fu #(.XLEN(32), .BYTES_PER_CYCLE(4)) dut32 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(in_valid_32), .in_ready(in_ready_32), .in_op(in_op_32),
        .in_rs1(in_rs1_32), .in_rs2(in_rs2_32),
        .out_valid(out_valid_32), .out_ready(out_ready_32), .out_rd(out_rd_32)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Output element j is table element rs1[j] when that index is below the element count.
    function automatic logic [63:0] ref_xperm(input int xlen, input logic op,
                                              input logic [63:0] rs1, input logic [63:0] rs2);
        int          esz = op ? 4 : 8;
        int          n   = xlen / esz;
        logic [63:0] mask = (64'd1 << esz) - 64'd1;
        logic [63:0] rd  = '0;
        for (int j = 0; j < n; j++) begin
            int idx = int'((rs1 >> (j * esz)) & mask);
            if (idx < n)
                rd |= ((rs2 >> (idx * esz)) & mask) << (j * esz);
        end
        return rd;
    endfunction

    function automatic logic [63:0] rand_idx(input int xlen, input logic op);
        logic [63:0] v = '0;
        for (int b = 0; b < xlen / 8; b++)
            v[b*8 +: 8] = $urandom_range(0, 3) == 0 ? 8'($urandom) :
                          op ? {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))}
                             : 8'($urandom_range(0, xlen / 8 + 1));
        return v;
    endfunction

    task automatic run64(input logic op, input logic [63:0] r1, input logic [63:0] r2,
                         input int hold, input string tag);
        logic [63:0] exp = ref_xperm(64, op, r1, r2);
        int          lat = 0;
        @(negedge clk);
        check({tag, " idle"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_op = op; in_rs1 = r1; in_rs2 = r2; out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = 1'($urandom);
        in_rs1 = {$urandom, $urandom}; in_rs2 = {$urandom, $urandom};
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(CHUNKS64));
        check({tag, " rd"}, out_rd, exp);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check({tag, " hold rd"}, out_rd, exp);
            check({tag, " hold valid/ready"}, {62'd0, out_valid, in_ready}, 64'b10);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " release"}, {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    task automatic run32(input logic op, input logic [31:0] r1, input logic [31:0] r2,
                         input string tag);
        logic [63:0] exp = ref_xperm(32, op, {32'd0, r1}, {32'd0, r2});
        int          lat = 0;
        @(negedge clk);
        in_valid_32 = 1'b1; in_op_32 = op; in_rs1_32 = r1; in_rs2_32 = r2;
        @(posedge clk); #1;
        in_valid_32 = 1'b0; in_rs1_32 = $urandom; in_rs2_32 = $urandom;
        while (!out_valid_32 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(CHUNKS32));
        check({tag, " rd"}, {32'd0, out_rd_32}, exp);
        @(posedge clk); #1;
        check({tag, " release"}, {62'd0, out_valid_32, in_ready_32}, 64'b01);
    endtask

    initial begin
        int seen;
        repeat (2) @(negedge clk);
        check("reset 64", {out_rd, 62'd0, out_valid, in_ready}, {64'd0, 64'd1});
        check("reset 32", {out_rd_32, 30'd0, out_valid_32, in_ready_32}, 64'd1);
        rst = 1'b0;

        run64(1'b0, 64'h0001020304050607, 64'h8877665544332211, 0, "s1 xperm8 rev");
        check("s1 literal", out_rd, 64'h1122334455667788);
        run64(1'b0, 64'h00000000000000FF, 64'h8877665544332211, 0, "s2 xperm8 oob");
        check("s2 literal", out_rd, 64'h1111111111111100);
        run64(1'b1, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 0, "s3 xperm4 id");
        check("s3 literal", out_rd, 64'h0123456789ABCDEF);
        run32(1'b0, 32'h04030201, 32'hDDCCBBAA, "s4 xperm8 32");
        check("s4 literal", {32'd0, out_rd_32}, 64'h0000000000DDCCBB);
        run32(1'b1, 32'h000000F8, 32'h76543210, "s4 xperm4 32");
        run64(1'b0, 64'h0001020304050607, 64'h8877665544332211, 5, "s5 backpressure");

        // flush during the second BUSY cycle drops the operation
        @(negedge clk);
        in_valid = 1'b1; in_op = 1'b0; in_rs1 = 64'h0706050403020100; in_rs2 = {$urandom, $urandom};
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush idle", {62'd0, out_valid, in_ready}, 64'b01);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            seen += int'(out_valid);
        end
        check("flush no result", 64'(seen), 64'd0);
        run64(1'b0, 64'h00000000000000FF, 64'h8877665544332211, 0, "s6 after flush");

        // asynchronous reset mid-BUSY takes effect between clock edges
        @(negedge clk);
        in_valid = 1'b1; in_op = 1'b1; in_rs1 = {$urandom, $urandom}; in_rs2 = {$urandom, $urandom};
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async rst", {out_rd, 62'd0, out_valid, in_ready}, {64'd0, 64'd1});
        #1 rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            seen += int'(out_valid);
        end
        check("rst no result", 64'(seen), 64'd0);
        run64(1'b1, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 0, "s6 after rst");

        for (int t = 0; t < 30; t++) begin
            logic op = 1'($urandom);
            run64(op, rand_idx(64, op), {$urandom, $urandom}, $urandom_range(0, 3), "rand64");
        end
        for (int t = 0; t < 20; t++) begin
            logic op = 1'($urandom);
            run32(op, 32'(rand_idx(32, op)), $urandom, "rand32");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/xperm_iter_fu.md
Name: xperm_iter_fu

Overview:
- Parametrised, multi-cycle crossbar-permutation unit for the crypto FU, implementing both Zbkx instructions, xperm8 and xperm4.
- Supports RV32 and RV64.
- Computes BYTES_PER_CYCLE output bytes per cycle so area can be traded against latency.
- Sits behind the FU issue stage with a valid/ready request interface and a valid/ready response interface.
- Adds full-index range checking, which the earlier 32-bit xperm8-only model did not do.

Parameters:
- XLEN, 64: operand width; legal values are 32 and 64.
- BYTES_PER_CYCLE, 2: output bytes produced per BUSY cycle; must divide XLEN/8.

Ports:
- clk  input  1  clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort; discards any in-flight operation.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- in_op  input  1  0 = xperm8, 1 = xperm4.
- in_rs1  input  XLEN  index vector.
- in_rs2  input  XLEN  lookup table.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_rd  output  XLEN  result.

Behaviour:
- Reset (asynchronous):
  - state = IDLE, chunk counter = 0, out_valid = 0, out_rd = 0, in_ready = 1.
  - All operand registers are cleared.
- Reset asserted mid-operation aborts immediately. No result is ever presented for the aborted request.
- Element sizes:
  - xperm8: element = 8 bits, N = XLEN/8 elements. Output element j = rs2 byte[rs1 byte j] if rs1 byte j < N, else 0.
  - The full 8-bit index is compared against N, not just its low bits. Example: index 0x04 with XLEN=32 gives 0.
  - xperm4: element = 4 bits, N = XLEN/4. Output nibble j = rs2 nibble[rs1 nibble j] if rs1 nibble j < N, else 0.
  - With XLEN=64 every nibble index is in range. With XLEN=32, indices 8..15 give 0.
- Derived constants:
  - CHUNKS = (XLEN/8)/BYTES_PER_CYCLE.
  - Counter width = max(1, clog2(CHUNKS)).
- State machine, IDLE -> BUSY -> DONE:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch rs1, rs2 and op, set counter = 0, go to BUSY.
  - BUSY: in_ready = 0. Each cycle, write out_rd bytes [counter*BYTES_PER_CYCLE +: BYTES_PER_CYCLE] from the latched operands. When counter == CHUNKS-1 go to DONE, otherwise increment the counter.
  - DONE: out_valid = 1 and out_rd is held stable. On out_ready go to IDLE and deassert out_valid.
  - A new request is not accepted in the same cycle as the handshake that leaves DONE.
- Latency: request accepted at edge t gives out_valid high after edge t+CHUNKS. Throughput is one operation per CHUNKS+2 cycles.
- Backpressure: while out_valid & !out_ready, out_rd and out_valid are unchanged and in_ready = 0.
- out_rd bytes not yet written in BUSY hold their previous values. They are not observable, because out_valid = 0.
- flush:
  - In any state, the next state is IDLE, counter = 0 and out_valid = 0.
  - flush takes priority over a simultaneous in_valid handshake (the request is dropped) and over out_ready.
  - out_rd is not required to clear.
- Operands are sampled only at acceptance. Changes to in_* during BUSY or DONE have no effect.

Decomposition:
- Package xperm_pkg holds:
  - op encodings XPERM_OP_8 = 1'b0 and XPERM_OP_4 = 1'b1;
  - the state encoding: IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  - a helper function computing CHUNKS.
- One natural sub-module, xperm_byte_lane: combinational.
  - Inputs: op, full XLEN lut, one index byte.
  - Output: one result byte, which is two nibble lookups when op = xperm4, including the range checks.
- The top instantiates BYTES_PER_CYCLE lanes behind a chunk-select mux.

Test Plan:
1. XLEN=64, xperm8, rs2=0x8877665544332211, rs1=0x0001020304050607 -> rd=0x1122334455667788; out_valid rises exactly 4 cycles after acceptance.
2. XLEN=64, xperm8, rs2=0x8877665544332211, rs1=0x00000000000000FF -> rd=0x1111111111111100 (out-of-range index gives 0).
3. XLEN=64, xperm4, rs2=0x0123456789ABCDEF, rs1=0xFEDCBA9876543210 -> rd=0x0123456789ABCDEF.
4. XLEN=32, BYTES_PER_CYCLE=4:
   - xperm8, rs2=0xDDCCBBAA, rs1=0x04030201 -> rd=0x00DDCCBB after 1 BUSY cycle.
   - xperm4, rs1=0x000000F8 -> low byte 0x00.
5. Backpressure: after scenario 1, hold out_ready=0 for 5 cycles -> rd stable at 0x1122334455667788, in_ready=0; then out_ready=1 -> IDLE next cycle and in_ready=1.
6. Abort:
   - flush in the 2nd BUSY cycle -> out_valid never rises and in_ready=1 next cycle; the next request (scenario 2) returns the correct rd.
   - Repeat the abort using rst asserted asynchronously mid-BUSY -> all outputs return to reset values without waiting for a clock edge.
